// File: rtl/elevator_car_model_if.sv
// rtl/elevator_car_model_if.sv - actuator/sensor bundle between controller and car model
//
// Purpose: groups the controller-to-plant commands and the plant-to-controller
//          sensor/status signals of the elevator car model.
// Signals:
//   ac          motor command (00 stop, 01 up, 10 down, 11 stop)
//   doorOpen    door command, 1 = open / hold open
//   s1..s3      one-cycle floor arrival pulses
//   floor       last floor reached (1..3)
//   pos         shaft position in ticks
//   moving      pos changed on the last edge
//   door_closed door fully closed
//   fault_door  sticky door interlock fault
//   fault_limit sticky travel limit fault
// Modports: master = controller/bench side, slave = car model side.

interface elevator_car_model_if;
  logic [1:0] ac;
  logic       doorOpen;
  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] floor;
  logic [7:0] pos;
  logic       moving;
  logic       door_closed;
  logic       fault_door;
  logic       fault_limit;

  modport master (
    output ac, doorOpen,
    input  s1, s2, s3, floor, pos, moving, door_closed, fault_door, fault_limit
  );

  modport slave (
    input  ac, doorOpen,
    output s1, s2, s3, floor, pos, moving, door_closed, fault_door, fault_limit
  );
endinterface

// File: rtl/elevator_car_model.sv
// rtl/elevator_car_model.sv - behavioural elevator car and shaft plant model
//
// Purpose: consumes motor/door commands and produces floor sensor pulses,
//          position, door status and sticky illegal-command faults.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   car    elevator_car_model_if.slave (ac, doorOpen in; sensors/status out)
// Parameters:
//   TRAVEL_CYCLES  ticks between adjacent floors (2..127)
//   DOOR_CYCLES    edges with doorOpen=0 before the door reports closed (1..255)

module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 5,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_car_model_if.slave  car
);

  localparam logic [7:0] FLOOR2_POS = 8'(TRAVEL_CYCLES);
  localparam logic [7:0] PMAX       = 8'(2 * TRAVEL_CYCLES);
  localparam logic [7:0] DOOR_LIM   = 8'(DOOR_CYCLES);

  typedef enum logic [1:0] {
    DOOR_SHUT,
    DOOR_OPEN,
    DOOR_CLOSING
  } door_state_t;

  door_state_t door_state, door_state_next;
  logic [7:0]  door_cnt, door_cnt_next;
  logic [7:0]  door_cnt_inc;

  logic        cmd_up, cmd_dn, door_ok, at_floor, pos_change;
  logic [7:0]  pos_next;

  // Door FSM state register; door_closed is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_state      <= DOOR_SHUT;
      door_cnt        <= 8'd0;
      car.door_closed <= 1'b1;
    end else begin
      door_state      <= door_state_next;
      door_cnt        <= door_cnt_next;
      car.door_closed <= (door_state_next == DOOR_SHUT);
    end
  end

  // Any edge with doorOpen=1 restarts the close sequence; the closing count
  // includes the first edge after doorOpen falls.
  always_comb begin
    door_state_next = door_state;
    door_cnt_next   = door_cnt;
    door_cnt_inc    = door_cnt + 8'd1;
    if (car.doorOpen) begin
      door_state_next = DOOR_OPEN;
      door_cnt_next   = 8'd0;
    end else begin
      case (door_state)
        DOOR_OPEN, DOOR_CLOSING: begin
          if (door_cnt_inc == DOOR_LIM) begin
            door_state_next = DOOR_SHUT;
            door_cnt_next   = 8'd0;
          end else begin
            door_state_next = DOOR_CLOSING;
            door_cnt_next   = door_cnt_inc;
          end
        end
        default: begin
          door_state_next = DOOR_SHUT;
          door_cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // Motion decode: the car only moves with the door shut and not being opened.
  always_comb begin
    cmd_up   = (car.ac == 2'b01);
    cmd_dn   = (car.ac == 2'b10);
    door_ok  = car.door_closed && !car.doorOpen;
    at_floor = (car.pos == 8'd0) || (car.pos == FLOOR2_POS) || (car.pos == PMAX);
    pos_next = car.pos;
    if (cmd_up && door_ok && (car.pos < PMAX)) begin
      pos_next = car.pos + 8'd1;
    end else if (cmd_dn && door_ok && (car.pos > 8'd0)) begin
      pos_next = car.pos - 8'd1;
    end
    pos_change = (pos_next != car.pos);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car.pos         <= 8'd0;
      car.floor       <= 2'd1;
      car.moving      <= 1'b0;
      car.s1          <= 1'b0;
      car.s2          <= 1'b0;
      car.s3          <= 1'b0;
      car.fault_door  <= 1'b0;
      car.fault_limit <= 1'b0;
    end else begin
      car.pos    <= pos_next;
      car.moving <= pos_change;
      // Pulses only on the edge that brings the car onto a floor position.
      car.s1     <= pos_change && (pos_next == 8'd0);
      car.s2     <= pos_change && (pos_next == FLOOR2_POS);
      car.s3     <= pos_change && (pos_next == PMAX);
      if (pos_change) begin
        if (pos_next == 8'd0) begin
          car.floor <= 2'd1;
        end else if (pos_next == FLOOR2_POS) begin
          car.floor <= 2'd2;
        end else if (pos_next == PMAX) begin
          car.floor <= 2'd3;
        end
      end
      if (((cmd_up || cmd_dn) && !door_ok) || (car.doorOpen && !at_floor)) begin
        car.fault_door <= 1'b1;
      end
      if ((cmd_up && (car.pos == PMAX)) || (cmd_dn && (car.pos == 8'd0))) begin
        car.fault_limit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// tb/tb_elevator_car_model.sv - directed self-checking bench for elevator_car_model

module tb_elevator_car_model;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  elevator_car_model_if bus();

  elevator_car_model #(
    .TRAVEL_CYCLES(5),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .car  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pos", bus.pos, 0);
    chk("rst_floor", bus.floor, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.ac = 2'b00;
    bus.doorOpen = 1'b0;

    // Reset asserted mid-cycle, checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("reset_pos", bus.pos, 0);
    chk("reset_floor", bus.floor, 1);
    chk("reset_s", {bus.s1, bus.s2, bus.s3}, 0);
    chk("reset_moving", bus.moving, 0);
    chk("reset_door_closed", bus.door_closed, 1);
    chk("reset_faults", {bus.fault_door, bus.fault_limit}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Climb from floor 1 to floor 3.
    bus.ac = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("climb_pos", bus.pos, i);
      chk("climb_moving", bus.moving, 1);
      chk("climb_s1", bus.s1, 0);
      chk("climb_s2", bus.s2, (i == 5) ? 1 : 0);
      chk("climb_s3", bus.s3, (i == 10) ? 1 : 0);
      chk("climb_floor", bus.floor, (i >= 10) ? 3 : ((i >= 5) ? 2 : 1));
      chk("climb_faults", {bus.fault_door, bus.fault_limit}, 0);
    end

    // Top limit.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("top_pos", bus.pos, 10);
      chk("top_moving", bus.moving, 0);
      chk("top_s", {bus.s1, bus.s2, bus.s3}, 0);
      chk("top_fault_limit", bus.fault_limit, 1);
      chk("top_floor", bus.floor, 3);
    end

    // Descend to floor 2.
    bus.ac = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("down_pos", bus.pos, 10 - i);
      chk("down_s2", bus.s2, (i == 5) ? 1 : 0);
      chk("down_floor", bus.floor, (i == 5) ? 2 : 3);
    end
    chk("down_fault_door", bus.fault_door, 0);

    // Door interlock at floor 2.
    bus.ac = 2'b00;
    bus.doorOpen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("door_open_closed", bus.door_closed, 0);
      chk("door_open_pos", bus.pos, 5);
    end
    chk("door_open_fault", bus.fault_door, 0);
    bus.doorOpen = 1'b0;
    bus.ac = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("interlock_pos", bus.pos, 5);
      chk("interlock_fault", bus.fault_door, 1);
      chk("interlock_door_closed", bus.door_closed, (i == 3) ? 1 : 0);
    end
    step();
    chk("interlock_release_pos", bus.pos, 4);
    chk("interlock_release_moving", bus.moving, 1);

    // Reversal mid-segment back to floor 1.
    bus.ac = 2'b00;
    pulse_reset();
    bus.ac = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("rev_up_pos", bus.pos, i);
      chk("rev_up_s", {bus.s1, bus.s2, bus.s3}, 0);
    end
    bus.ac = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("rev_dn_pos", bus.pos, 3 - i);
      chk("rev_dn_s1", bus.s1, (i == 3) ? 1 : 0);
      chk("rev_dn_s2", bus.s2, 0);
      chk("rev_dn_floor", bus.floor, 1);
    end
    bus.ac = 2'b00;
    step();
    chk("rev_s1_falls", bus.s1, 0);

    // Reset mid-travel.
    bus.ac = 2'b01;
    for (int i = 1; i <= 7; i++) step();
    chk("mid_pos", bus.pos, 7);
    chk("mid_floor", bus.floor, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_pos", bus.pos, 0);
    chk("mid_rst_floor", bus.floor, 1);
    chk("mid_rst_moving", bus.moving, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_hold_pos", bus.pos, 0);
      chk("mid_hold_s3", bus.s3, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("mid_release_pos", bus.pos, 1);
    chk("mid_release_moving", bus.moving, 1);
    chk("mid_release_s1", bus.s1, 0);

    // Door opened between floors.
    bus.ac = 2'b00;
    bus.doorOpen = 1'b1;
    step();
    chk("offfloor_fault_door", bus.fault_door, 1);
    chk("offfloor_door_closed", bus.door_closed, 0);
    chk("offfloor_pos", bus.pos, 1);
    chk("offfloor_fault_limit", bus.fault_limit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
